// File: rtl/traffic_lamp_monitor.sv
// Safety monitor between the traffic controller and the physical lamps.
// It registers the lamp drive and filters glitches. It traps illegal
// encodings, conflicting greens/yellows and illegal colour steps. A
// persistent violation latches a fault and flashes red on both roads
// until an operator clear followed by a safe restart (both roads red).
module traffic_lamp_monitor #(
   parameter int unsigned FILT_CYC  = 2,
   parameter int unsigned BLINK_CYC = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] road1_in,
   input  logic [2:0] road2_in,
   input  logic       fault_clr,
   output logic [2:0] road1_lamp,
   output logic [2:0] road2_lamp,
   output logic       fault,
   output logic [2:0] fault_code
);

   localparam logic [2:0] RED = 3'b001;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b100;
   localparam logic [2:0] OFF = 3'b000;

   localparam logic [2:0] CODE_BAD  = 3'b001;
   localparam logic [2:0] CODE_CONF = 3'b010;
   localparam logic [2:0] CODE_SEQ  = 3'b100;

   localparam logic [7:0]  FILT_LIM   = 8'(FILT_CYC);
   localparam logic [15:0] BLINK_LAST = 16'(BLINK_CYC - 1);

   typedef enum logic [1:0] {
      S_INIT,
      S_NORMAL,
      S_FLASH,
      S_RECOVER
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  road1_lamp_q, road1_lamp_d;
   logic [2:0]  road2_lamp_q, road2_lamp_d;
   logic        fault_q, fault_d;
   logic [2:0]  fault_code_q, fault_code_d;
   logic [7:0]  filt_cnt_q, filt_cnt_d;
   logic [15:0] blink_cnt_q, blink_cnt_d;

   logic        bad;
   logic        conflict;
   logic        seq_err;
   logic        violation;
   logic [2:0]  cause;
   logic        both_red;

   function automatic logic one_hot(input logic [2:0] c);
      return (c == RED) || (c == YEL) || (c == GRN);
   endfunction

   // Legal steps: hold, R->Y, Y->G, G->Y, Y->R. R<->G jumps are illegal.
   function automatic logic step_ok(input logic [2:0] lamp, input logic [2:0] c);
      logic ok;
      ok = (c == lamp);
      case (lamp)
         RED:     ok = ok || (c == YEL);
         YEL:     ok = ok || (c == GRN) || (c == RED);
         GRN:     ok = ok || (c == YEL);
         default: ok = ok;
      endcase
      return ok;
   endfunction

   // Classify this cycle's inputs against the lamps currently driven.
   always_comb begin
      bad       = !one_hot(road1_in) || !one_hot(road2_in);
      conflict  = !bad && (road1_in != RED) && (road2_in != RED);
      seq_err   = !step_ok(road1_lamp_q, road1_in) || !step_ok(road2_lamp_q, road2_in);
      violation = bad || conflict || seq_err;
      both_red  = (road1_in == RED) && (road2_in == RED);
      if (bad)           cause = CODE_BAD;
      else if (conflict) cause = CODE_CONF;
      else               cause = CODE_SEQ;
   end

   // Next-state and next-output logic for the monitor FSM.
   always_comb begin
      state_d      = state_q;
      road1_lamp_d = road1_lamp_q;
      road2_lamp_d = road2_lamp_q;
      fault_d      = fault_q;
      fault_code_d = fault_code_q;
      filt_cnt_d   = filt_cnt_q;
      blink_cnt_d  = blink_cnt_q;
      case (state_q)
         S_INIT: begin
            road1_lamp_d = RED;
            road2_lamp_d = RED;
            if (both_red) state_d = S_NORMAL;
         end
         S_NORMAL: begin
            if (!violation) begin
               road1_lamp_d = road1_in;
               road2_lamp_d = road2_in;
               filt_cnt_d   = 8'd0;
            end else if (filt_cnt_q + 8'd1 == FILT_LIM) begin
               // Trip: the first flash cycle shows red, so load RED here.
               state_d      = S_FLASH;
               fault_d      = 1'b1;
               fault_code_d = cause;
               blink_cnt_d  = 16'd0;
               filt_cnt_d   = 8'd0;
               road1_lamp_d = RED;
               road2_lamp_d = RED;
            end else begin
               filt_cnt_d = filt_cnt_q + 8'd1;
            end
         end
         S_FLASH: begin
            if (fault_clr) begin
               state_d      = S_RECOVER;
               road1_lamp_d = RED;
               road2_lamp_d = RED;
               blink_cnt_d  = 16'd0;
            end else if (blink_cnt_q == BLINK_LAST) begin
               // The lamp register itself holds the flash phase.
               blink_cnt_d  = 16'd0;
               road1_lamp_d = (road1_lamp_q == RED) ? OFF : RED;
               road2_lamp_d = (road1_lamp_q == RED) ? OFF : RED;
            end else begin
               blink_cnt_d = blink_cnt_q + 16'd1;
            end
         end
         S_RECOVER: begin
            road1_lamp_d = RED;
            road2_lamp_d = RED;
            if (both_red) begin
               state_d      = S_NORMAL;
               fault_d      = 1'b0;
               fault_code_d = OFF;
               filt_cnt_d   = 8'd0;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_INIT;
         road1_lamp_q <= RED;
         road2_lamp_q <= RED;
         fault_q      <= 1'b0;
         fault_code_q <= 3'b000;
         filt_cnt_q   <= 8'd0;
         blink_cnt_q  <= 16'd0;
      end else begin
         state_q      <= state_d;
         road1_lamp_q <= road1_lamp_d;
         road2_lamp_q <= road2_lamp_d;
         fault_q      <= fault_d;
         fault_code_q <= fault_code_d;
         filt_cnt_q   <= filt_cnt_d;
         blink_cnt_q  <= blink_cnt_d;
      end
   end

   assign road1_lamp = road1_lamp_q;
   assign road2_lamp = road2_lamp_q;
   assign fault      = fault_q;
   assign fault_code = fault_code_q;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Bench for traffic_lamp_monitor: two instances (filter 2 and filter 1)
// share the stimulus and are compared each cycle against a colour-index
// reference model, plus directed scenarios with fixed expectations.
module tb_traffic_lamp_monitor;

   localparam int BLINK = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] road1_in, road2_in;
   logic       fault_clr;
   logic [2:0] a_l1, a_l2, a_code, b_l1, b_l2, b_code;
   logic       a_flt, b_flt;

   int checks = 0;
   int errors = 0;

   logic [2:0] ctl1 [8] = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001};
   logic [2:0] ctl2 [8] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b010, 3'b001};

   typedef struct {
      int         st;     // 0 idle-wait, 1 running, 2 flashing, 3 awaiting restart
      logic [2:0] l1, l2;
      logic       flt;
      logic [2:0] code;
      int         cnt;
      int         age;
   } model_t;

   model_t ma, mb;

   always #5 clk = ~clk;

   traffic_lamp_monitor #(.FILT_CYC(2), .BLINK_CYC(BLINK)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .road1_in(road1_in), .road2_in(road2_in),
      .fault_clr(fault_clr), .road1_lamp(a_l1), .road2_lamp(a_l2),
      .fault(a_flt), .fault_code(a_code));

   traffic_lamp_monitor #(.FILT_CYC(1), .BLINK_CYC(BLINK)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .road1_in(road1_in), .road2_in(road2_in),
      .fault_clr(fault_clr), .road1_lamp(b_l1), .road2_lamp(b_l2),
      .fault(b_flt), .fault_code(b_code));

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Colour index: red 0, yellow 1, green 2; anything else is far away.
   function automatic int colour(input logic [2:0] c);
      case (c)
         3'b001:  return 0;
         3'b010:  return 1;
         3'b100:  return 2;
         default: return -100;
      endcase
   endfunction

   function automatic model_t step(input model_t m, input int filt, input logic [2:0] r1,
                                   input logic [2:0] r2, input logic clr, input logic rn);
      model_t n;
      int     d1, d2;
      bit     bad, conf, seq;
      n = m;
      if (!rn) begin
         n.st = 0; n.l1 = 3'b001; n.l2 = 3'b001; n.flt = 1'b0;
         n.code = 3'b000; n.cnt = 0; n.age = 0;
         return n;
      end
      case (m.st)
         0: begin
            n.l1 = 3'b001; n.l2 = 3'b001;
            if (r1 == 3'b001 && r2 == 3'b001) n.st = 1;
         end
         1: begin
            bad  = (colour(r1) < 0) || (colour(r2) < 0);
            conf = !bad && colour(r1) != 0 && colour(r2) != 0;
            d1   = colour(r1) - colour(m.l1);
            d2   = colour(r2) - colour(m.l2);
            seq  = (d1 > 1) || (d1 < -1) || (d2 > 1) || (d2 < -1);
            if (!(bad || conf || seq)) begin
               n.l1 = r1; n.l2 = r2; n.cnt = 0;
            end else begin
               n.cnt = m.cnt + 1;
               if (n.cnt >= filt) begin
                  n.st = 2; n.flt = 1'b1; n.age = 0; n.cnt = 0;
                  n.code = bad ? 3'b001 : (conf ? 3'b010 : 3'b100);
                  n.l1 = 3'b001; n.l2 = 3'b001;
               end
            end
         end
         2: begin
            if (clr) begin
               n.st = 3; n.l1 = 3'b001; n.l2 = 3'b001;
            end else begin
               n.age = m.age + 1;
               n.l1 = (((n.age / BLINK) % 2) == 0) ? 3'b001 : 3'b000;
               n.l2 = n.l1;
            end
         end
         default: begin
            n.l1 = 3'b001; n.l2 = 3'b001;
            if (r1 == 3'b001 && r2 == 3'b001) begin
               n.st = 1; n.flt = 1'b0; n.code = 3'b000; n.cnt = 0;
            end
         end
      endcase
      return n;
   endfunction

   // Drive one cycle, advance both models on the edge, compare just after it.
   task automatic cyc(input logic [2:0] r1, input logic [2:0] r2, input logic clr, input logic rn);
      road1_in = r1; road2_in = r2; fault_clr = clr; rst_n = rn;
      @(posedge clk);
      ma = step(ma, 2, r1, r2, clr, rn);
      mb = step(mb, 1, r1, r2, clr, rn);
      #1;
      check_eq("a.lamp1", 16'(a_l1), 16'(ma.l1));
      check_eq("a.lamp2", 16'(a_l2), 16'(ma.l2));
      check_eq("a.fault", 16'(a_flt), 16'(ma.flt));
      check_eq("a.code", 16'(a_code), 16'(ma.code));
      check_eq("b.lamp1", 16'(b_l1), 16'(mb.l1));
      check_eq("b.lamp2", 16'(b_l2), 16'(mb.l2));
      check_eq("b.fault", 16'(b_flt), 16'(mb.flt));
      check_eq("b.code", 16'(b_code), 16'(mb.code));
   endtask

   task automatic go_normal();
      cyc(3'b001, 3'b001, 1'b0, 1'b0);
      cyc(3'b001, 3'b001, 1'b0, 1'b1);
   endtask

   task automatic restart();
      cyc(3'b001, 3'b001, 1'b1, 1'b1);
      cyc(3'b001, 3'b001, 1'b0, 1'b1);
   endtask

   initial begin
      int         r, idx;
      logic [2:0] a, b;
      logic       c, rn;
      rst_n = 1'b0; road1_in = 3'b010; road2_in = 3'b001; fault_clr = 1'b0;
      ma = step(ma, 2, 3'b0, 3'b0, 1'b0, 1'b0);
      mb = ma;

      // Reset state
      cyc(3'b010, 3'b001, 1'b0, 1'b0);
      check_eq("rst.lamp1", 16'(a_l1), 16'h1);
      check_eq("rst.fault", 16'(a_flt), 16'h0);
      check_eq("rst.code", 16'(a_code), 16'h0);

      // Full controller cycle, lamps follow one cycle later
      cyc(3'b001, 3'b001, 1'b0, 1'b1);
      for (int k = 0; k < 8; k++) begin
         cyc(ctl1[k], ctl2[k], 1'b0, 1'b1);
         check_eq("t1.lamp1", 16'(a_l1), 16'(ctl1[k]));
         check_eq("t1.lamp2", 16'(a_l2), 16'(ctl2[k]));
         check_eq("t1.fault", 16'(a_flt), 16'h0);
      end

      // One-cycle conflict glitch filtered, two cycles trip
      cyc(3'b010, 3'b001, 1'b0, 1'b1);
      cyc(3'b100, 3'b001, 1'b0, 1'b1);
      cyc(3'b100, 3'b100, 1'b0, 1'b1);
      check_eq("t2.glitch_l2", 16'(a_l2), 16'h1);
      cyc(3'b100, 3'b001, 1'b0, 1'b1);
      check_eq("t2.noflt", 16'(a_flt), 16'h0);
      cyc(3'b100, 3'b100, 1'b0, 1'b1);
      cyc(3'b100, 3'b100, 1'b0, 1'b1);
      check_eq("t2.fault", 16'(a_flt), 16'h1);
      check_eq("t2.code", 16'(a_code), 16'h2);
      for (int k = 1; k < 12; k++) begin
         cyc(3'b100, 3'b001, 1'b0, 1'b1);
         check_eq("t2.flash", 16'(a_l1), ((k / 4) % 2 == 0) ? 16'h1 : 16'h0);
      end

      // Sequence fault, bad code, priority; recover in between
      cyc(3'b100, 3'b001, 1'b1, 1'b1);
      check_eq("t4.rec_fault", 16'(a_flt), 16'h1);
      check_eq("t4.rec_lamp", 16'(a_l1), 16'h1);
      cyc(3'b001, 3'b001, 1'b0, 1'b1);
      check_eq("t4.clr_fault", 16'(a_flt), 16'h0);
      check_eq("t4.clr_code", 16'(a_code), 16'h0);
      cyc(3'b010, 3'b001, 1'b1, 1'b1);
      cyc(3'b100, 3'b001, 1'b1, 1'b1);
      check_eq("t4.clr_ignored", 16'(a_l1), 16'h4);
      cyc(3'b001, 3'b001, 1'b0, 1'b1);
      cyc(3'b001, 3'b001, 1'b0, 1'b1);
      check_eq("t3.seq", 16'(a_code), 16'h4);
      restart();
      cyc(3'b011, 3'b001, 1'b0, 1'b1);
      cyc(3'b011, 3'b001, 1'b0, 1'b1);
      check_eq("t3.bad", 16'(a_code), 16'h1);
      restart();
      cyc(3'b110, 3'b010, 1'b0, 1'b1);
      cyc(3'b110, 3'b010, 1'b0, 1'b1);
      check_eq("t3.prio", 16'(a_code), 16'h1);

      // Reset mid-flash while the lamps are dark
      for (int k = 0; k < 4; k++) cyc(3'b010, 3'b001, 1'b0, 1'b1);
      check_eq("t5.dark", 16'(a_l1), 16'h0);
      cyc(3'b010, 3'b001, 1'b0, 1'b0);
      check_eq("t5.rst_lamp", 16'(a_l1), 16'h1);
      check_eq("t5.rst_fault", 16'(a_flt), 16'h0);
      cyc(3'b010, 3'b001, 1'b0, 1'b1);
      cyc(3'b010, 3'b001, 1'b0, 1'b1);
      check_eq("t5.init_hold", 16'(a_l1), 16'h1);
      cyc(3'b001, 3'b001, 1'b0, 1'b1);
      cyc(3'b010, 3'b001, 1'b0, 1'b1);
      check_eq("t5.normal", 16'(a_l1), 16'h2);

      // Single-cycle trip with a one-cycle filter
      go_normal();
      cyc(3'b010, 3'b010, 1'b0, 1'b1);
      check_eq("t6.b_fault", 16'(b_flt), 16'h1);
      check_eq("t6.b_code", 16'(b_code), 16'h2);
      check_eq("t6.b_lamp2", 16'(b_l2), 16'h1);
      check_eq("t6.a_nofault", 16'(a_flt), 16'h0);

      // Randomized traffic with glitches, clears and resets
      idx = 0;
      go_normal();
      for (int i = 0; i < 4000; i++) begin
         r = int'($urandom_range(99));
         c = 1'b0; rn = 1'b1;
         a = ctl1[idx]; b = ctl2[idx];
         if (r < 55) begin
            if ($urandom_range(2) == 0) idx = (idx + 1) % 8;
            a = ctl1[idx]; b = ctl2[idx];
         end else if (r < 70) begin
            a = 3'($urandom_range(7)); b = 3'($urandom_range(7));
         end else if (r < 85) begin
            idx = 0; a = 3'b001; b = 3'b001; c = 1'($urandom_range(1));
         end else if (r < 98) begin
            c = 1'b1;
         end else begin
            rn = 1'b0;
         end
         cyc(a, b, c, rn);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
